// File: rtl/fft_frame_scheduler_pkg.sv
// Shared types and constants for the FFT frame scheduler: FSM encoding,
// grant side encoding and the round-robin grant helper.
package fft_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_LOAD  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } sched_state_e;

    localparam logic GRANT_FWD = 1'b0;
    localparam logic GRANT_INV = 1'b1;

    // With both sides requesting, the side that did not go last wins.
    function automatic logic rr_pick(input logic req_fwd, input logic req_inv,
                                     input logic last_grant);
        logic pick;
        if (req_fwd && req_inv) begin
            pick = ~last_grant;
        end else if (req_inv) begin
            pick = GRANT_INV;
        end else begin
            pick = GRANT_FWD;
        end
        return pick;
    endfunction

endpackage

// File: rtl/fft_frame_scheduler_if.sv
// Handshake bundle between the frame scheduler and the FFT/FIFO datapath.
// master = scheduler side, slave = datapath/control side.
interface fft_frame_scheduler_if;
    logic req_fwd;
    logic req_inv;
    logic src_empty_fwd;
    logic src_empty_inv;
    logic src_rdreq_fwd;
    logic src_rdreq_inv;
    logic sel_inv;
    logic fft_inverse;
    logic fft_sink_valid;
    logic fft_sink_sop;
    logic fft_sink_eop;
    logic fft_sink_ready;
    logic fft_source_valid;
    logic fft_source_eop;
    logic fft_source_ready;
    logic dst_full_fwd;
    logic dst_full_inv;
    logic dst_wrreq_fwd;
    logic dst_wrreq_inv;
    logic done_fwd;
    logic done_inv;
    logic busy;
    logic err;

    modport master (
        input  req_fwd, req_inv, src_empty_fwd, src_empty_inv, fft_sink_ready,
               fft_source_valid, fft_source_eop, dst_full_fwd, dst_full_inv,
        output src_rdreq_fwd, src_rdreq_inv, sel_inv, fft_inverse, fft_sink_valid,
               fft_sink_sop, fft_sink_eop, fft_source_ready, dst_wrreq_fwd,
               dst_wrreq_inv, done_fwd, done_inv, busy, err
    );

    modport slave (
        output req_fwd, req_inv, src_empty_fwd, src_empty_inv, fft_sink_ready,
               fft_source_valid, fft_source_eop, dst_full_fwd, dst_full_inv,
        input  src_rdreq_fwd, src_rdreq_inv, sel_inv, fft_inverse, fft_sink_valid,
               fft_sink_sop, fft_sink_eop, fft_source_ready, dst_wrreq_fwd,
               dst_wrreq_inv, done_fwd, done_inv, busy, err
    );
endinterface

// File: rtl/fft_frame_scheduler_frame_counter.sv
// Beat counter with enable, synchronous clear (clear wins) and a flag that is
// high while the count sits at its terminal value.
module frame_counter #(
    parameter int CNT_W = 6,
    parameter int TERM  = 63
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             term
);
    localparam logic [CNT_W-1:0] TERM_C = CNT_W'(TERM);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;

    // Count accepted beats; clear returns to zero at frame end.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (en) begin
            cnt_r <= cnt_r + ONE_C;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt  = cnt_r;
    assign term = (cnt_r == TERM_C);
endmodule

// File: rtl/fft_frame_scheduler.sv
// Time-shares one FFT core between the forward and inverse frame sources,
// one whole frame (load then drain) per grant, round-robin under contention.
module fft_frame_scheduler
    import fft_sched_pkg::*;
#(
    parameter int FRAME_LEN = 64,
    parameter int CNT_W     = 6
) (
    input logic                   clock,
    input logic                   reset,
    fft_frame_scheduler_if.master bus
);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(FRAME_LEN - 1);

    sched_state_e     state_r, state_nxt_s;
    logic             sel_inv_r, sel_nxt_s;
    logic             last_grant_r;
    logic             err_r, done_fwd_r, done_inv_r, busy_r;
    logic [CNT_W-1:0] in_cnt_s, out_cnt_s;
    logic             in_term_s, out_term_s;
    logic             src_empty_sel_s, dst_full_sel_s;
    logic             sink_valid_s, in_acc_s, src_ready_s, out_acc_s;
    logic             out_last_s, len_err_s;

    // Handshake decode for the granted side; only live in LOAD / DRAIN.
    always_comb begin
        src_empty_sel_s = sel_inv_r ? bus.src_empty_inv : bus.src_empty_fwd;
        dst_full_sel_s  = sel_inv_r ? bus.dst_full_inv  : bus.dst_full_fwd;
        sink_valid_s    = (state_r == ST_LOAD)  && !src_empty_sel_s;
        in_acc_s        = sink_valid_s && bus.fft_sink_ready;
        src_ready_s     = (state_r == ST_DRAIN) && !dst_full_sel_s;
        out_acc_s       = bus.fft_source_valid && src_ready_s;
        out_last_s      = out_acc_s && (bus.fft_source_eop || out_term_s);
        // Early or late eop relative to the result count.
        len_err_s       = out_acc_s && (bus.fft_source_eop ^ (out_cnt_s == LAST_C));
    end

    // Next-state and grant selection.
    always_comb begin
        state_nxt_s = state_r;
        sel_nxt_s   = sel_inv_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.req_fwd || bus.req_inv) begin
                    sel_nxt_s   = rr_pick(bus.req_fwd, bus.req_inv, last_grant_r);
                    state_nxt_s = ST_GRANT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GRANT: state_nxt_s = ST_LOAD;
            ST_LOAD: begin
                if (in_acc_s && in_term_s) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_DRAIN: begin
                if (out_last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, grant bookkeeping and the registered status outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            sel_inv_r    <= GRANT_FWD;
            last_grant_r <= GRANT_INV;
            err_r        <= 1'b0;
            done_fwd_r   <= 1'b0;
            done_inv_r   <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            sel_inv_r    <= sel_nxt_s;
            last_grant_r <= (state_r == ST_DONE) ? sel_inv_r : last_grant_r;
            err_r        <= err_r || len_err_s;
            done_fwd_r   <= (state_nxt_s == ST_DONE) && (sel_inv_r == GRANT_FWD);
            done_inv_r   <= (state_nxt_s == ST_DONE) && (sel_inv_r == GRANT_INV);
            busy_r       <= (state_nxt_s != ST_IDLE);
        end
    end

    frame_counter #(.CNT_W(CNT_W), .TERM(FRAME_LEN - 1)) u_in_cnt (
        .clock (clock),
        .reset (reset),
        .clr   (in_acc_s && in_term_s),
        .en    (in_acc_s),
        .cnt   (in_cnt_s),
        .term  (in_term_s)
    );

    frame_counter #(.CNT_W(CNT_W), .TERM(FRAME_LEN - 1)) u_out_cnt (
        .clock (clock),
        .reset (reset),
        .clr   (out_last_s),
        .en    (out_acc_s),
        .cnt   (out_cnt_s),
        .term  (out_term_s)
    );

    assign bus.src_rdreq_fwd    = in_acc_s && (sel_inv_r == GRANT_FWD);
    assign bus.src_rdreq_inv    = in_acc_s && (sel_inv_r == GRANT_INV);
    assign bus.fft_sink_valid   = sink_valid_s;
    assign bus.fft_sink_sop     = sink_valid_s && (in_cnt_s == '0);
    assign bus.fft_sink_eop     = sink_valid_s && in_term_s;
    assign bus.fft_source_ready = src_ready_s;
    assign bus.dst_wrreq_fwd    = out_acc_s && (sel_inv_r == GRANT_FWD);
    assign bus.dst_wrreq_inv    = out_acc_s && (sel_inv_r == GRANT_INV);
    assign bus.sel_inv          = sel_inv_r;
    assign bus.fft_inverse      = sel_inv_r;
    assign bus.done_fwd         = done_fwd_r;
    assign bus.done_inv         = done_inv_r;
    assign bus.busy             = busy_r;
    assign bus.err              = err_r;
endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Directed bench for fft_frame_scheduler: plays the FIFOs and the FFT core
// around the scheduler and checks frame counts, grant order, stalls and errors.
module tb_fft_frame_scheduler;
    import fft_sched_pkg::*;

    localparam int FRAME_LEN = 64;
    localparam int CNT_W     = 6;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    fft_frame_scheduler_if bus_if ();

    fft_frame_scheduler #(.FRAME_LEN(FRAME_LEN), .CNT_W(CNT_W)) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    int n_vec = 0;
    int n_err = 0;

    // Per-frame tallies filled by run_frame.
    int rd_fwd_n, rd_inv_n, wr_fwd_n, wr_inv_n;
    int sop_n, sop_at, eop_n, eop_at, done_fwd_n, done_inv_n, gap_bad;
    int sel_seen, inv_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Runs one frame from the current cycle until two cycles after its done pulse.
    // emp_at/full_at = beat index where the source empties / destination fills.
    task automatic run_frame(input int emp_at, input int emp_len, input int full_at,
                             input int full_len, input int eop_idx, input bit keep_req);
        int in_b, out_b, ge, gf, post, cyc;
        bit out_done, seen_done, emp, full, src_v;
        rd_fwd_n = 0; rd_inv_n = 0; wr_fwd_n = 0; wr_inv_n = 0;
        sop_n = 0; sop_at = -1; eop_n = 0; eop_at = -1;
        done_fwd_n = 0; done_inv_n = 0; gap_bad = 0; sel_seen = -1; inv_seen = -1;
        in_b = 0; out_b = 0; ge = 0; gf = 0; post = 0; cyc = 0;
        out_done = 1'b0; seen_done = 1'b0;
        while (post < 2 && cyc < 400) begin
            emp   = (in_b == emp_at) && (ge < emp_len);
            full  = (in_b == FRAME_LEN) && (out_b == full_at) && (gf < full_len);
            src_v = (in_b == FRAME_LEN) && !out_done;
            bus_if.src_empty_fwd    = emp;
            bus_if.src_empty_inv    = emp;
            bus_if.dst_full_fwd     = full;
            bus_if.dst_full_inv     = full;
            bus_if.fft_source_valid = src_v;
            bus_if.fft_source_eop   = src_v && (out_b == eop_idx);
            #1;
            if (emp) begin
                ge++;
                if (bus_if.fft_sink_valid || bus_if.src_rdreq_fwd || bus_if.src_rdreq_inv)
                    gap_bad++;
                if (int'(u_dut.in_cnt_s) != emp_at) gap_bad++;
            end
            if (full) begin
                gf++;
                if (bus_if.fft_source_ready || bus_if.dst_wrreq_fwd || bus_if.dst_wrreq_inv)
                    gap_bad++;
            end
            if (bus_if.src_rdreq_fwd || bus_if.src_rdreq_inv) begin
                if (in_b == 0) begin
                    sel_seen = int'(bus_if.sel_inv);
                    inv_seen = int'(bus_if.fft_inverse);
                end
                if (bus_if.fft_sink_sop) begin sop_n++; sop_at = in_b; end
                if (bus_if.fft_sink_eop) begin eop_n++; eop_at = in_b; end
                in_b++;
                if (in_b == FRAME_LEN && !keep_req) begin
                    bus_if.req_fwd = 1'b0;
                    bus_if.req_inv = 1'b0;
                end
            end
            rd_fwd_n += int'(bus_if.src_rdreq_fwd);
            rd_inv_n += int'(bus_if.src_rdreq_inv);
            wr_fwd_n += int'(bus_if.dst_wrreq_fwd);
            wr_inv_n += int'(bus_if.dst_wrreq_inv);
            if (bus_if.dst_wrreq_fwd || bus_if.dst_wrreq_inv) begin
                if (bus_if.fft_source_eop || out_b == FRAME_LEN - 1) out_done = 1'b1;
                out_b++;
            end
            done_fwd_n += int'(bus_if.done_fwd);
            done_inv_n += int'(bus_if.done_inv);
            if (seen_done) post++;
            else if (bus_if.done_fwd || bus_if.done_inv) seen_done = 1'b1;
            @(posedge clock);
            @(negedge clock);
            cyc++;
        end
        chk("frame_completed", {31'd0, seen_done}, 32'd1);
        bus_if.src_empty_fwd = 1'b0; bus_if.src_empty_inv = 1'b0;
        bus_if.dst_full_fwd = 1'b0; bus_if.dst_full_inv = 1'b0;
        bus_if.fft_source_valid = 1'b0; bus_if.fft_source_eop = 1'b0;
    endtask

    initial begin
        int beats;
        reset = 1'b1;
        bus_if.req_fwd = 1'b0; bus_if.req_inv = 1'b0;
        bus_if.src_empty_fwd = 1'b0; bus_if.src_empty_inv = 1'b0;
        bus_if.fft_sink_ready = 1'b1;
        bus_if.fft_source_valid = 1'b0; bus_if.fft_source_eop = 1'b0;
        bus_if.dst_full_fwd = 1'b0; bus_if.dst_full_inv = 1'b0;
        @(negedge clock); @(negedge clock); #1;
        chk("rst_busy", {31'd0, bus_if.busy}, 32'd0);
        chk("rst_sel_inv", {31'd0, bus_if.sel_inv}, 32'd0);
        chk("rst_err", {31'd0, bus_if.err}, 32'd0);
        chk("rst_strobes", {28'd0, bus_if.src_rdreq_fwd, bus_if.fft_sink_valid,
                            bus_if.done_fwd, bus_if.done_inv}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Contention: fwd, inv, fwd.
        bus_if.req_fwd = 1'b1; bus_if.req_inv = 1'b1;
        run_frame(-1, 0, -1, 0, 63, 1'b1);
        chk("cont1_sel", sel_seen, 0);
        chk("cont1_fftinv", inv_seen, 0);
        chk("cont1_rd_fwd", rd_fwd_n, 64);
        chk("cont1_done_fwd", done_fwd_n, 1);
        run_frame(-1, 0, -1, 0, 63, 1'b1);
        chk("cont2_sel", sel_seen, 1);
        chk("cont2_fftinv", inv_seen, 1);
        chk("cont2_wr_inv", wr_inv_n, 64);
        chk("cont2_done_inv", done_inv_n, 1);
        run_frame(-1, 0, -1, 0, 63, 1'b0);
        chk("cont3_sel", sel_seen, 0);
        chk("cont3_rd_fwd", rd_fwd_n, 64);

        // Single forward frame.
        bus_if.req_fwd = 1'b1;
        run_frame(-1, 0, -1, 0, 63, 1'b0);
        chk("fwd_rd_fwd", rd_fwd_n, 64);
        chk("fwd_rd_inv", rd_inv_n, 0);
        chk("fwd_sop_n", sop_n, 1);
        chk("fwd_sop_at", sop_at, 0);
        chk("fwd_eop_n", eop_n, 1);
        chk("fwd_eop_at", eop_at, 63);
        chk("fwd_wr_fwd", wr_fwd_n, 64);
        chk("fwd_done_fwd", done_fwd_n, 1);
        chk("fwd_done_inv", done_inv_n, 0);
        chk("fwd_err", {31'd0, bus_if.err}, 32'd0);
        chk("fwd_idle", {31'd0, bus_if.busy}, 32'd0);

        // Source underflow after beat 10 for 5 cycles.
        bus_if.req_fwd = 1'b1;
        run_frame(10, 5, -1, 0, 63, 1'b0);
        chk("uflow_gap", gap_bad, 0);
        chk("uflow_rd", rd_fwd_n, 64);
        chk("uflow_eop_n", eop_n, 1);
        chk("uflow_eop_at", eop_at, 63);

        // Inverse frame with destination full for 8 cycles mid-drain.
        bus_if.req_inv = 1'b1;
        run_frame(-1, 0, 30, 8, 63, 1'b0);
        chk("bp_gap", gap_bad, 0);
        chk("bp_wr_inv", wr_inv_n, 64);
        chk("bp_wr_fwd", wr_fwd_n, 0);
        chk("bp_done_inv", done_inv_n, 1);
        chk("bp_sel", sel_seen, 1);

        // Early eop on result 40, then a clean frame.
        bus_if.req_fwd = 1'b1;
        run_frame(-1, 0, -1, 0, 40, 1'b0);
        chk("eeop_wr", wr_fwd_n, 41);
        chk("eeop_done", done_fwd_n, 1);
        chk("eeop_err", {31'd0, bus_if.err}, 32'd1);
        bus_if.req_fwd = 1'b1;
        run_frame(-1, 0, -1, 0, 63, 1'b0);
        chk("post_eeop_wr", wr_fwd_n, 64);
        chk("post_eeop_err_sticky", {31'd0, bus_if.err}, 32'd1);

        // Reset in the middle of LOAD, at beat 20.
        bus_if.req_fwd = 1'b1;
        beats = 0;
        for (int c = 0; c < 100 && beats < 20; c++) begin
            #1;
            beats += int'(bus_if.src_rdreq_fwd);
            @(posedge clock);
            @(negedge clock);
        end
        chk("mid_beats", beats, 20);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_strobes", {27'd0, bus_if.src_rdreq_fwd, bus_if.fft_sink_valid,
                                bus_if.fft_sink_sop, bus_if.fft_sink_eop, bus_if.busy}, 32'd0);
        chk("mid_rst_state", {29'd0, u_dut.state_r}, {29'd0, ST_IDLE});
        chk("mid_rst_err", {31'd0, bus_if.err}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        run_frame(-1, 0, -1, 0, 63, 1'b0);
        chk("after_rst_sop_at", sop_at, 0);
        chk("after_rst_rd", rd_fwd_n, 64);
        chk("after_rst_eop_at", eop_at, 63);
        chk("after_rst_wr", wr_fwd_n, 64);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
